// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: shared op encodings, FSM states and TAP sequence constants for the JTAG scan master.
package jtag_master_pkg;
    typedef enum logic [1:0] {OP_DR = 2'b00, OP_IR = 2'b01, OP_RST = 2'b10, OP_IDLE = 2'b11} op_e;
    typedef enum logic [2:0] {RST_SEQ, IDLE, PRE, SHIFT, POST, RESP} state_e;
    localparam int RST_TMS_ONES = 5;
    localparam int PRE_DR = 3;
    localparam int PRE_IR = 4;
    function automatic logic pre_tms(op_e op, int n);
        return op == OP_IR ? n < 2 : n == 0;
    endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into TCK and flags the clk edges that will toggle it.
module jtag_tck_gen #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);
    localparam int CW = $clog2(HALF_PERIOD + 1);
    logic [CW-1:0] cnt;
    logic wrap;
    assign wrap = en && cnt == CW'(HALF_PERIOD - 1);
    assign rise_stb = wrap && !tck;
    assign fall_stb = wrap && tck;
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            tck <= !tck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: turns host scan commands into TCK/TMS/TDI traffic and returns captured TDO.
module jtag_scan_master
    import jtag_master_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int HALF_PERIOD = 2,
    parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    state_e state;
    op_e op_q;
    logic [LEN_W-1:0] len_q, bit_cnt;
    logic [MAX_LEN-1:0] dat, mask;
    logic rst_cmd, en, fall_stb, rise_stb, scan, pre_last, bad_len;
    assign en = state inside {RST_SEQ, PRE, SHIFT, POST};
    assign scan = op_q == OP_DR || op_q == OP_IR;
    assign pre_last = bit_cnt == LEN_W'((op_q == OP_IR ? PRE_IR : PRE_DR) - 1);
    assign bad_len = cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN);
    jtag_tck_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tck (
        .clk(clk), .rst(rst), .en(en), .tck(tck), .fall_stb(fall_stb), .rise_stb(rise_stb)
    );
    // Each state presents TMS/TDI for its next TCK on the fall strobe ending the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_SEQ;
            op_q <= OP_DR;
            len_q <= '0;
            bit_cnt <= '0;
            dat <= '0;
            mask <= '0;
            rst_cmd <= 1'b0;
            tms <= 1'b1;
            tdi <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                RST_SEQ: if (fall_stb) begin
                    if (bit_cnt == LEN_W'(RST_TMS_ONES)) begin
                        state <= rst_cmd ? RESP : IDLE;
                        rsp_valid <= rst_cmd;
                        cmd_ready <= !rst_cmd;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + LEN_W'(1);
                        tms <= bit_cnt < LEN_W'(RST_TMS_ONES - 1);
                    end
                end
                IDLE: if (cmd_valid && cmd_ready) begin
                    op_q <= op_e'(cmd_op);
                    len_q <= cmd_len;
                    dat <= cmd_data;
                    bit_cnt <= '0;
                    rst_cmd <= cmd_op == OP_RST;
                    cmd_ready <= 1'b0;
                    rsp_data <= '0;
                    rsp_err <= 1'b0;
                    if (cmd_op == OP_RST) begin
                        state <= RST_SEQ;
                        tms <= 1'b1;
                    end else if (cmd_op == OP_IDLE) begin
                        state <= cmd_len == '0 ? RESP : SHIFT;
                        rsp_valid <= cmd_len == '0;
                        tms <= cmd_len == '0 ? tms : 1'b0;
                    end else if (bad_len) begin
                        state <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err <= 1'b1;
                    end else begin
                        state <= PRE;
                        tms <= 1'b1;
                    end
                end
                PRE: if (fall_stb) begin
                    if (pre_last) begin
                        state <= SHIFT;
                        bit_cnt <= '0;
                        tms <= len_q == LEN_W'(1);
                        tdi <= dat[0];
                        dat <= dat >> 1;
                        mask <= MAX_LEN'(1);
                    end else begin
                        bit_cnt <= bit_cnt + LEN_W'(1);
                        tms <= pre_tms(op_q, int'(bit_cnt) + 1);
                    end
                end
                SHIFT: begin
                    if (rise_stb && scan)
                        rsp_data <= rsp_data | (tdo ? mask : '0);
                    if (fall_stb) begin
                        if (bit_cnt == len_q - LEN_W'(1)) begin
                            state <= scan ? POST : RESP;
                            rsp_valid <= !scan;
                            tms <= scan;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + LEN_W'(1);
                            tms <= scan && bit_cnt + LEN_W'(2) == len_q;
                            tdi <= scan ? dat[0] : tdi;
                            dat <= dat >> 1;
                            mask <= mask << 1;
                        end
                    end
                end
                POST: if (fall_stb) begin
                    if (bit_cnt == LEN_W'(1)) begin
                        state <= RESP;
                        rsp_valid <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= LEN_W'(1);
                        tms <= 1'b0;
                    end
                end
                RESP: if (rsp_ready) begin
                    state <= IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= RST_SEQ;
            endcase
        end
    end
endmodule
